mem_access_unit: RTL and testbench

MEM-stage load/store unit of the RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It drives the data-memory bus with a valid/ready handshake, generates store byte enables, and aligns and sign-extends load data. It presents the write-back triple (data, rd address, register enable) that MEM/WB captures every cycle, and raises `stall` to freeze upstream stages while a bus access is outstanding.

---
 rtl/rv32_pkg.sv | 18 +
 rtl/load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: funct3 encodings for loads/stores and the MEM-stage FSM states.
package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword and zero- or sign-extends it.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: bus handshake with wait/timeout FSM, store lanes,
// alignment check and combinational write-back triple for MEM/WB.
module mem_access_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_enable_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_enable,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_timeout
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    logic        mem_op, is_load, is_store, misaligned;
    logic [1:0]  size;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata_i  (bus_rdata),
        .addr_i   (alu_result[1:0]),
        .funct3_i (funct3),
        .data_o   (load_data)
    );

    // Both flags set decodes as a load, so a store needs mem_read low.
    assign mem_op   = valid_in & (mem_read | mem_write);
    assign is_load  = valid_in & mem_read;
    assign is_store = valid_in & mem_write & ~mem_read;
    assign size     = funct3[1:0];
    assign misaligned = ((size == 2'b01) & alu_result[0]) | (size[1] & (|alu_result[1:0]));

    always_comb begin
        case (size)
            2'b00: begin
                lane_be    = 4'b0001 << alu_result[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << alu_result[1:0];
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bus_req       = 1'b0;
        stall         = 1'b0;
        misalign_err  = 1'b0;
        bus_timeout   = 1'b0;
        wb_reg_enable = reg_enable_in & valid_in & ~mem_op;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_err = 1'b1;
                    end else begin
                        bus_req = 1'b1;
                        if (bus_ready) begin
                            wb_reg_enable = is_load & reg_enable_in;
                        end else begin
                            stall   = 1'b1;
                            state_d = BUSY;
                            count_d = '0;
                        end
                    end
                end
            end
            BUSY: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                count_d = count_q + 1'b1;
                // Ready is checked first so it wins over a coincident timeout.
                if (bus_ready) begin
                    stall         = 1'b0;
                    wb_reg_enable = is_load & reg_enable_in;
                    state_d       = IDLE;
                end else if (count_q == LAST) begin
                    bus_req     = 1'b0;
                    stall       = 1'b0;
                    bus_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_we     = bus_req & is_store;
        bus_addr   = bus_req ? {alu_result[31:2], 2'b00} : '0;
        bus_wdata  = bus_we ? lane_wdata : '0;
        bus_be     = bus_we ? lane_be : '0;
        wb_data    = is_load ? load_data : alu_result;
        wb_rd_addr = rd_addr_in;

        if (reset) begin
            bus_req       = 1'b0;
            bus_we        = 1'b0;
            bus_addr      = '0;
            bus_wdata     = '0;
            bus_be        = '0;
            stall         = 1'b0;
            misalign_err  = 1'b0;
            bus_timeout   = 1'b0;
            wb_data       = '0;
            wb_rd_addr    = '0;
            wb_reg_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd_addr_in;
    logic        reg_enable_in;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_enable;
    logic        stall;
    logic        misalign_err;
    logic        bus_timeout;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .funct3        (funct3),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .rd_addr_in    (rd_addr_in),
        .reg_enable_in (reg_enable_in),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .wb_data       (wb_data),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_enable (wb_reg_enable),
        .stall         (stall),
        .misalign_err  (misalign_err),
        .bus_timeout   (bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic rdy,
                         input logic [31:0] rdat);
        valid_in      = v;
        mem_read      = rd;
        mem_write     = wr;
        funct3        = f3;
        alu_result    = addr;
        store_data    = sd;
        bus_ready     = rdy;
        bus_rdata     = rdat;
        rd_addr_in    = 5'd7;
        reg_enable_in = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // Reset with a pending load on the inputs: everything must read 0.
        reset = 1'b1;
        drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        tick();
        tick();
        sample();
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_en", {31'b0, wb_reg_enable}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        reset = 1'b0;

        // Non-memory instruction, then an invalid slot.
        tick();
        drive(1, 0, 0, 3'b000, 32'h12345678, 32'h0, 0, 32'h0);
        sample();
        chk("alu_wb_data", wb_data, 32'h12345678);
        chk("alu_wb_en", {31'b0, wb_reg_enable}, 32'd1);
        chk("alu_wb_rd", {27'b0, wb_rd_addr}, 32'd7);
        chk("alu_bus_req", {31'b0, bus_req}, 32'd0);
        tick();
        drive(0, 0, 0, 3'b000, 32'h12345678, 32'h0, 0, 32'h0);
        sample();
        chk("inv_wb_en", {31'b0, wb_reg_enable}, 32'd0);

        // Zero-wait LW at 0x100.
        tick();
        drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        sample();
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_wb_en", {31'b0, wb_reg_enable}, 32'd1);
        chk("lw_stall", {31'b0, stall}, 32'd0);
        chk("lw_bus_req", {31'b0, bus_req}, 32'd1);
        chk("lw_bus_addr", bus_addr, 32'h100);
        chk("lw_bus_be", {28'b0, bus_be}, 32'd0);

        // Back-to-back byte/halfword loads from rdata 0x80FF1234.
        tick();
        drive(1, 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234);
        sample();
        chk("lb_data", wb_data, 32'hFFFFFF80);
        chk("lb_addr", bus_addr, 32'h100);
        tick();
        drive(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
        sample();
        chk("lbu_data", wb_data, 32'h00000080);
        tick();
        drive(1, 1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234);
        sample();
        chk("lh_data", wb_data, 32'hFFFF80FF);
        tick();
        drive(1, 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF1234);
        sample();
        chk("lhu_data", wb_data, 32'h00001234);

        // Stores.
        tick();
        drive(1, 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);
        sample();
        chk("sh_be", {28'b0, bus_be}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_addr", bus_addr, 32'h200);
        chk("sh_we", {31'b0, bus_we}, 32'd1);
        chk("sh_wb_en", {31'b0, wb_reg_enable}, 32'd0);
        tick();
        drive(1, 0, 1, 3'b000, 32'h201, 32'h11223344, 1, 32'h0);
        sample();
        chk("sb_be", {28'b0, bus_be}, 32'h2);
        chk("sb_wdata", bus_wdata, 32'h44444444);
        tick();
        drive(1, 0, 1, 3'b010, 32'h204, 32'h89ABCDEF, 1, 32'h0);
        sample();
        chk("sw_be", {28'b0, bus_be}, 32'hF);
        chk("sw_wdata", bus_wdata, 32'h89ABCDEF);

        // Misaligned word load.
        tick();
        drive(1, 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
        sample();
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_bus_req", {31'b0, bus_req}, 32'd0);
        chk("mis_wb_en", {31'b0, wb_reg_enable}, 32'd0);
        chk("mis_stall", {31'b0, stall}, 32'd0);

        // LW with three wait cycles.
        tick();
        drive(1, 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        sample();
        chk("ws_stall0", {31'b0, stall}, 32'd1);
        chk("ws_bubble0", {31'b0, wb_reg_enable}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            sample();
            chk("ws_stall", {31'b0, stall}, 32'd1);
            chk("ws_bubble", {31'b0, wb_reg_enable}, 32'd0);
            chk("ws_req_held", {31'b0, bus_req}, 32'd1);
        end
        tick();
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        sample();
        chk("ws_done_stall", {31'b0, stall}, 32'd0);
        chk("ws_done_en", {31'b0, wb_reg_enable}, 32'd1);
        chk("ws_done_data", wb_data, 32'hCAFEF00D);
        tick();
        drive(1, 0, 0, 3'b000, 32'h5, 32'h0, 0, 32'h0);
        sample();
        chk("ws_idle_stall", {31'b0, stall}, 32'd0);

        // Timeout: request cycle, three wait cycles, abort on the fourth wait cycle.
        tick();
        drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h0);
        sample();
        chk("to_stall0", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            chk("to_wait_stall", {31'b0, stall}, 32'd1);
            chk("to_wait_flag", {31'b0, bus_timeout}, 32'd0);
        end
        tick();
        sample();
        chk("to_pulse", {31'b0, bus_timeout}, 32'd1);
        chk("to_req", {31'b0, bus_req}, 32'd0);
        chk("to_stall", {31'b0, stall}, 32'd0);
        chk("to_wb_en", {31'b0, wb_reg_enable}, 32'd0);
        tick();
        drive(1, 0, 0, 3'b000, 32'h6, 32'h0, 0, 32'h0);
        sample();
        chk("to_idle_stall", {31'b0, stall}, 32'd0);
        chk("to_idle_flag", {31'b0, bus_timeout}, 32'd0);

        // Reset while BUSY.
        tick();
        drive(1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0);
        tick();
        sample();
        chk("rm_busy_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        sample();
        chk("rm_req", {31'b0, bus_req}, 32'd0);
        chk("rm_stall", {31'b0, stall}, 32'd0);
        chk("rm_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        tick();
        sample();
        chk("rm_after_stall", {31'b0, stall}, 32'd0);
        chk("rm_after_req", {31'b0, bus_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
